// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: turns vend/change pulses into motor runs and hopper pulses,
// tracks product stock and gates coin acceptance.
module vend_dispense_ctrl #(
  parameter int unsigned STOCK_W       = 8,
  parameter int unsigned INIT_STOCK    = 10,
  parameter int unsigned MOTOR_TIMEOUT = 200,
  parameter int unsigned CHANGE_PULSE  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vend_req,
  input  logic               change_req,
  input  logic               motor_done,
  input  logic               restock_valid,
  input  logic [STOCK_W-1:0] restock_qty,
  input  logic               fault_clear,
  output logic               motor_on,
  output logic               hopper_pulse,
  output logic               coin_enable,
  output logic               busy,
  output logic               fault,
  output logic               drop_err,
  output logic [STOCK_W-1:0] stock_count
);

  localparam int unsigned CntW = (CHANGE_PULSE > 1) ? $clog2(CHANGE_PULSE) : 1;
  localparam logic [15:0] TimeoutLast = 16'(MOTOR_TIMEOUT - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(CHANGE_PULSE - 1);

  typedef enum logic [1:0] {StIdle, StMotor, StChange, StFault} state_e;

  state_e              state_q, state_d;
  logic [15:0]         timer_q, timer_d;
  logic [CntW-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic                change_pending_q, change_pending_d;
  logic                drop_err_q, drop_err_d;
  logic [STOCK_W-1:0]  stock_q, stock_d;
  logic [STOCK_W:0]    restock_sum;
  logic [STOCK_W-1:0]  restock_sat;
  logic                stock_empty;

  assign stock_empty = (stock_q == '0);
  // One extra bit catches overflow so the add can saturate at all-ones.
  assign restock_sum = {1'b0, stock_q} + {1'b0, restock_qty};
  assign restock_sat = restock_sum[STOCK_W] ? {STOCK_W{1'b1}} : restock_sum[STOCK_W-1:0];

  always_comb begin
    state_d          = state_q;
    timer_d          = timer_q;
    pulse_cnt_d      = pulse_cnt_q;
    change_pending_d = change_pending_q;
    stock_d          = stock_q;
    drop_err_d       = vend_req && ((state_q != StIdle) || stock_empty);

    unique case (state_q)
      StIdle: begin
        // Vend decision sees pre-restock stock; restock still lands this cycle.
        if (vend_req && !stock_empty) begin
          state_d          = StMotor;
          timer_d          = '0;
          change_pending_d = change_req;
        end
        if (restock_valid) stock_d = restock_sat;
      end
      StMotor: begin
        if (motor_done) begin
          stock_d = stock_q - STOCK_W'(1);
          if (change_pending_q) begin
            state_d     = StChange;
            pulse_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (timer_q == TimeoutLast) begin
          state_d          = StFault;
          change_pending_d = 1'b0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StChange: begin
        if (pulse_cnt_q == PulseLast) begin
          state_d          = StIdle;
          change_pending_d = 1'b0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + CntW'(1);
        end
      end
      StFault: begin
        if (restock_valid) stock_d = restock_sat;
        if (fault_clear) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      timer_q          <= '0;
      pulse_cnt_q      <= '0;
      change_pending_q <= 1'b0;
      drop_err_q       <= 1'b0;
      stock_q          <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      pulse_cnt_q      <= pulse_cnt_d;
      change_pending_q <= change_pending_d;
      drop_err_q       <= drop_err_d;
      stock_q          <= stock_d;
    end
  end

  assign motor_on     = (state_q == StMotor);
  assign hopper_pulse = (state_q == StChange);
  assign busy         = (state_q == StMotor) || (state_q == StChange);
  assign fault        = (state_q == StFault);
  assign coin_enable  = (state_q == StIdle) && !stock_empty;
  assign drop_err     = drop_err_q;
  assign stock_count  = stock_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scenario bench for vend_dispense_ctrl; expected stock after each motor run is
// queued at vend time and checked when motor_on falls.
module tb_vend_dispense_ctrl;

  logic       clk;
  logic       reset;
  logic       vend_req;
  logic       change_req;
  logic       motor_done;
  logic       restock_valid;
  logic [7:0] restock_qty;
  logic       fault_clear;
  logic       motor_on;
  logic       hopper_pulse;
  logic       coin_enable;
  logic       busy;
  logic       fault;
  logic       drop_err;
  logic [7:0] stock_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_stock;
  logic [7:0] exp_pop;
  logic       motor_prev;

  vend_dispense_ctrl #(
    .STOCK_W      (8),
    .INIT_STOCK   (10),
    .MOTOR_TIMEOUT(200),
    .CHANGE_PULSE (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vend_req     (vend_req),
    .change_req   (change_req),
    .motor_done   (motor_done),
    .restock_valid(restock_valid),
    .restock_qty  (restock_qty),
    .fault_clear  (fault_clear),
    .motor_on     (motor_on),
    .hopper_pulse (hopper_pulse),
    .coin_enable  (coin_enable),
    .busy         (busy),
    .fault        (fault),
    .drop_err     (drop_err),
    .stock_count  (stock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Scoreboard: each completed motor run pops one expected stock value.
  always @(negedge clk) begin
    if (reset) begin
      motor_prev = 1'b0;
    end else begin
      if (motor_prev && !motor_on) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_run: stock=%0d with no expected entry", stock_count);
        end else begin
          exp_pop = exp_q.pop_front();
          if (stock_count !== exp_pop) begin
            n_fail++;
            $display("FAIL sb_stock: got %0d, required %0d", stock_count, exp_pop);
          end
        end
      end
      motor_prev = motor_on;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vend(input logic chg);
    vend_req   = 1'b1;
    change_req = chg;
    tick();
    vend_req   = 1'b0;
    change_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({motor_on, hopper_pulse, busy, fault, drop_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_drives: got %b, required 00000",
               {motor_on, hopper_pulse, busy, fault, drop_err});
    end
    n_checks++;
    if (stock_count !== 8'd10 || coin_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stock: got stock=%0d ce=%b, required stock=10 ce=1",
               stock_count, coin_enable);
    end
    model_stock = 8'd10;
  endtask

  task automatic test_vend_plain();
    int hi = 0;
    int hop = 0;
    model_stock = model_stock - 8'd1;
    exp_q.push_back(model_stock);
    vend(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (motor_on) hi++;
      if (hopper_pulse) hop++;
      if (i == 4) motor_done = 1'b1;
      tick();
    end
    motor_done = 1'b0;
    n_checks++;
    if (hi != 5 || motor_on !== 1'b0) begin
      n_fail++;
      $display("FAIL plain_motor: got %0d high cycles (now %b), required 5 then 0", hi, motor_on);
    end
    for (int i = 0; i < 4; i++) begin
      if (hopper_pulse) hop++;
      tick();
    end
    n_checks++;
    if (hop != 0) begin
      n_fail++;
      $display("FAIL plain_hopper: got %0d hopper cycles, required 0", hop);
    end
    n_checks++;
    if (stock_count !== 8'd9 || coin_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL plain_idle: got stock=%0d ce=%b, required stock=9 ce=1",
               stock_count, coin_enable);
    end
  endtask

  task automatic test_vend_change();
    int hop = 0;
    model_stock = model_stock - 8'd1;
    exp_q.push_back(model_stock);
    vend(1'b1);
    repeat (2) tick();
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
    n_checks++;
    if (motor_on !== 1'b0 || hopper_pulse !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL change_entry: got motor=%b hopper=%b busy=%b, required 0 1 1",
               motor_on, hopper_pulse, busy);
    end
    for (int i = 0; i < 12; i++) begin
      if (hopper_pulse) hop++;
      tick();
    end
    n_checks++;
    if (hop != 4) begin
      n_fail++;
      $display("FAIL change_len: got %0d hopper cycles, required 4", hop);
    end
    n_checks++;
    if (busy !== 1'b0 || coin_enable !== 1'b1 || stock_count !== 8'd8) begin
      n_fail++;
      $display("FAIL change_exit: got busy=%b ce=%b stock=%0d, required 0 1 8",
               busy, coin_enable, stock_count);
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    exp_q.push_back(model_stock);
    vend(1'b0);
    while (motor_on && hi < 300) begin
      hi++;
      tick();
    end
    n_checks++;
    if (hi != 200) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d motor cycles, required 200", hi);
    end
    n_checks++;
    if (fault !== 1'b1 || coin_enable !== 1'b0 || busy !== 1'b0 || stock_count !== 8'd8) begin
      n_fail++;
      $display("FAIL timeout_state: got fault=%b ce=%b busy=%b stock=%0d, required 1 0 0 8",
               fault, coin_enable, busy, stock_count);
    end
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
    tick();
    n_checks++;
    if (stock_count !== 8'd8 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_done_ignored: got stock=%0d fault=%b, required 8 1",
               stock_count, fault);
    end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || coin_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_clear: got fault=%b ce=%b, required 0 1", fault, coin_enable);
    end
  endtask

  task automatic test_empty_restock();
    while (model_stock != 0) begin
      model_stock = model_stock - 8'd1;
      exp_q.push_back(model_stock);
      vend(1'b0);
      motor_done = 1'b1;
      tick();
      motor_done = 1'b0;
      tick();
    end
    n_checks++;
    if (stock_count !== 8'd0 || coin_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL empty: got stock=%0d ce=%b, required 0 0", stock_count, coin_enable);
    end
    // Vend and restock together: vend judged on empty stock, restock still applied.
    restock_valid = 1'b1;
    restock_qty   = 8'd3;
    vend(1'b0);
    restock_valid = 1'b0;
    model_stock   = 8'd3;
    n_checks++;
    if (drop_err !== 1'b1 || motor_on !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_drop: got drop_err=%b motor=%b, required 1 0", drop_err, motor_on);
    end
    n_checks++;
    if (stock_count !== 8'd3 || coin_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL restock3: got stock=%0d ce=%b, required 3 1", stock_count, coin_enable);
    end
    tick();
    n_checks++;
    if (drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_pulse: got drop_err=%b, required 0 one cycle later", drop_err);
    end
  endtask

  task automatic test_saturate();
    restock_valid = 1'b1;
    restock_qty   = 8'd247;
    tick();
    n_checks++;
    if (stock_count !== 8'd250) begin
      n_fail++;
      $display("FAIL restock250: got %0d, required 250", stock_count);
    end
    restock_qty = 8'd20;
    tick();
    restock_valid = 1'b0;
    n_checks++;
    if (stock_count !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate: got %0d, required 255", stock_count);
    end
    model_stock = 8'd254;
    exp_q.push_back(model_stock);
    vend(1'b0);
    restock_valid = 1'b1;
    restock_qty   = 8'd5;
    tick();
    restock_valid = 1'b0;
    n_checks++;
    if (stock_count !== 8'd255 || motor_on !== 1'b1) begin
      n_fail++;
      $display("FAIL restock_in_motor: got stock=%0d motor=%b, required 255 1",
               stock_count, motor_on);
    end
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    model_stock = model_stock - 8'd1;
    exp_q.push_back(model_stock);
    vend(1'b0);
    vend(1'b1);
    n_checks++;
    if (drop_err !== 1'b1 || motor_on !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_drop: got drop_err=%b motor=%b, required 1 1", drop_err, motor_on);
    end
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
    n_checks++;
    if (motor_on !== 1'b0 || hopper_pulse !== 1'b0 || stock_count !== 8'd253) begin
      n_fail++;
      $display("FAIL busy_unaffected: got motor=%b hopper=%b stock=%0d, required 0 0 253",
               motor_on, hopper_pulse, stock_count);
    end
    tick();
    vend(1'b1);
    tick();
    reset = 1'b1;
    #2;
    n_checks++;
    if (motor_on !== 1'b0 || busy !== 1'b0 || stock_count !== 8'd10) begin
      n_fail++;
      $display("FAIL async_reset: got motor=%b busy=%b stock=%0d, required 0 0 10",
               motor_on, busy, stock_count);
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (coin_enable !== 1'b1 || hopper_pulse !== 1'b0 || stock_count !== 8'd10) begin
      n_fail++;
      $display("FAIL post_reset: got ce=%b hopper=%b stock=%0d, required 1 0 10",
               coin_enable, hopper_pulse, stock_count);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending entries, required 0", exp_q.size());
    end
  endtask

  initial begin
    reset         = 1'b1;
    vend_req      = 1'b0;
    change_req    = 1'b0;
    motor_done    = 1'b0;
    restock_valid = 1'b0;
    restock_qty   = 8'd0;
    fault_clear   = 1'b0;
    model_stock   = 8'd10;
    test_reset();
    test_vend_plain();
    test_vend_change();
    test_timeout();
    test_empty_restock();
    test_saturate();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
